// File: rtl/rdi_pkg.sv
// Package for the RDI state controller.
// Holds the adapter request and PHY status encodings, the internal FSM
// state type, the default LinkError residency, and the mapping from
// FSM state to the status code published to the adapter.
package rdi_pkg;

    // Adapter request encodings on lp_state_req.
    typedef enum logic [3:0] {
        LP_NOP       = 4'b0000,
        LP_ACTIVE    = 4'b0001,
        LP_LINKRESET = 4'b1001,
        LP_DISABLED  = 4'b1100
    } lp_state_req_e;

    // Status encodings published on pl_state_sts.
    typedef enum logic [3:0] {
        STS_RESET     = 4'b0000,
        STS_ACTIVE    = 4'b0001,
        STS_LINKRESET = 4'b1001,
        STS_DISABLED  = 4'b1100,
        STS_LINKERROR = 4'b1010
    } pl_state_sts_e;

    // Internal controller states. COUNT reports the same status as RESET.
    typedef enum logic [2:0] {
        ST_RESET,
        ST_COUNT,
        ST_ACTIVE,
        ST_LINKRESET,
        ST_DISABLED,
        ST_LINKERROR
    } rdi_state_e;

    // Default minimum LinkError residency after the error deasserts.
    localparam int unsigned LINKERR_MIN_CYC_DEF = 16;

    function automatic pl_state_sts_e sts_of(input rdi_state_e st);
        pl_state_sts_e s;
        s = STS_RESET;
        case (st)
            ST_RESET:     s = STS_RESET;
            ST_COUNT:     s = STS_RESET;
            ST_ACTIVE:    s = STS_ACTIVE;
            ST_LINKRESET: s = STS_LINKRESET;
            ST_DISABLED:  s = STS_DISABLED;
            ST_LINKERROR: s = STS_LINKERROR;
            default:      s = STS_RESET;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rdi_state_ctrl.sv
// RDI-side state controller, upstream of reset_counter.
// Tracks the adapter's state/wake requests, enables reset_counter while
// bringing the link up, and publishes the RDI status back to the adapter.
// Ports:
//   i_clk               divided sideband clock (shared with reset_counter)
//   i_rst               asynchronous, active-high reset
//   i_lp_state_req[3:0] adapter state request
//   i_lp_wake_req       adapter wake request (level)
//   i_lp_linkerror      adapter LinkError indication (level)
//   i_phy_linkup        PHY link up (level)
//   i_reset_count_done  reset_counter done (valid while o_count_en=1)
//   o_count_en          enable to reset_counter, high only in COUNT
//   o_pl_wake_ack       registered wake acknowledge (0 in LINKERROR)
//   o_pl_inband_pres    registered i_phy_linkup
//   o_pl_state_sts[3:0] registered status code of the FSM state
module rdi_state_ctrl
    import rdi_pkg::*;
#(
    parameter int unsigned LINKERR_MIN_CYC = LINKERR_MIN_CYC_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_lp_state_req,
    input  logic       i_lp_wake_req,
    input  logic       i_lp_linkerror,
    input  logic       i_phy_linkup,
    input  logic       i_reset_count_done,
    output logic       o_count_en,
    output logic       o_pl_wake_ack,
    output logic       o_pl_inband_pres,
    output logic [3:0] o_pl_state_sts
);

    localparam int unsigned CNT_W = $clog2(LINKERR_MIN_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LINKERR_MIN_CYC);

    rdi_state_e     state_q;
    rdi_state_e     state_d;
    logic [CNT_W-1:0] res_cnt_q;
    pl_state_sts_e  sts_q;
    logic           count_en_q;
    logic           wake_ack_q;
    logic           inband_pres_q;

    logic req_active;
    logic req_linkreset;
    logic req_disabled;

    assign req_active    = (i_lp_state_req == LP_ACTIVE);
    assign req_linkreset = (i_lp_state_req == LP_LINKRESET);
    assign req_disabled  = (i_lp_state_req == LP_DISABLED);

    // Next-state logic; linkerror is checked first in every state so it
    // wins over any other transition on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: begin
                if (i_lp_linkerror)
                    state_d = ST_LINKERROR;
                else if (inband_pres_q && wake_ack_q && req_active)
                    state_d = ST_COUNT;
            end
            ST_COUNT: begin
                // Abort has priority over done.
                if (i_lp_linkerror)
                    state_d = ST_LINKERROR;
                else if (!i_phy_linkup || !i_lp_wake_req || !req_active)
                    state_d = ST_RESET;
                else if (i_reset_count_done)
                    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (i_lp_linkerror || !i_phy_linkup)
                    state_d = ST_LINKERROR;
                else if (req_linkreset)
                    state_d = ST_LINKRESET;
                else if (req_disabled)
                    state_d = ST_DISABLED;
            end
            ST_LINKRESET: begin
                if (i_lp_linkerror)
                    state_d = ST_LINKERROR;
                else if (req_active)
                    state_d = ST_RESET;
                else if (req_disabled)
                    state_d = ST_DISABLED;
            end
            ST_DISABLED: begin
                if (i_lp_linkerror)
                    state_d = ST_LINKERROR;
                else if (req_active)
                    state_d = ST_RESET;
            end
            ST_LINKERROR: begin
                if (!i_lp_linkerror && (res_cnt_q == CNT_MAX))
                    state_d = ST_RESET;
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= ST_RESET;
        else
            state_q <= state_d;
    end

    // Residency counter: zero outside LINKERROR, on the entry edge and while
    // the error is held; otherwise counts up and saturates.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            res_cnt_q <= '0;
        else if ((state_q != ST_LINKERROR) || (state_d != ST_LINKERROR) || i_lp_linkerror)
            res_cnt_q <= '0;
        else if (res_cnt_q != CNT_MAX)
            res_cnt_q <= res_cnt_q + CNT_W'(1);
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself (count_en drops on the edge leaving COUNT).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sts_q         <= STS_RESET;
            count_en_q    <= 1'b0;
            wake_ack_q    <= 1'b0;
            inband_pres_q <= 1'b0;
        end else begin
            sts_q         <= sts_of(state_d);
            count_en_q    <= (state_d == ST_COUNT);
            wake_ack_q    <= (state_d == ST_LINKERROR) ? 1'b0 : i_lp_wake_req;
            inband_pres_q <= i_phy_linkup;
        end
    end

    assign o_pl_state_sts   = sts_q;
    assign o_count_en       = count_en_q;
    assign o_pl_wake_ack    = wake_ack_q;
    assign o_pl_inband_pres = inband_pres_q;

endmodule

// File: tb/tb_rdi_state_ctrl.sv
module tb_rdi_state_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       wake;
    logic       lerr;
    logic       linkup;
    logic       done;
    logic       cen;
    logic       ack;
    logic       pres;
    logic [3:0] sts;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rdi_state_ctrl #(.LINKERR_MIN_CYC(16)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_lp_state_req     (req),
        .i_lp_wake_req      (wake),
        .i_lp_linkerror     (lerr),
        .i_phy_linkup       (linkup),
        .i_reset_count_done (done),
        .o_count_en         (cen),
        .o_pl_wake_ack      (ack),
        .o_pl_inband_pres   (pres),
        .o_pl_state_sts     (sts)
    );

    typedef struct {
        logic [3:0] req;
        logic       wake;
        logic       lerr;
        logic       linkup;
        logic       done;
        logic [3:0] e_sts;
        logic       e_cen;
        logic       e_ack;
        logic       e_pres;
    } vec_t;

    vec_t vecs[23];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] e_sts, input logic e_cen,
                           input logic e_ack, input logic e_pres);
        chk({name, ".sts"},  sts, e_sts);
        chk({name, ".cen"},  {3'b0, cen},  {3'b0, e_cen});
        chk({name, ".ack"},  {3'b0, ack},  {3'b0, e_ack});
        chk({name, ".pres"}, {3'b0, pres}, {3'b0, e_pres});
    endtask

    initial begin
        int n;
        bit seen_active;

        //         req    wake lerr up  done  sts    cen  ack  pres
        vecs[0]  = '{4'h1, 1, 0, 1, 0, 4'h0, 0, 1, 1}; // regs load linkup/wake
        vecs[1]  = '{4'h1, 1, 0, 1, 0, 4'h0, 1, 1, 1}; // RESET -> COUNT
        vecs[2]  = '{4'h1, 1, 0, 1, 1, 4'h1, 0, 1, 1}; // done -> ACTIVE
        vecs[3]  = '{4'h0, 1, 0, 1, 0, 4'h1, 0, 1, 1}; // NOP holds ACTIVE
        vecs[4]  = '{4'h9, 1, 0, 1, 0, 4'h9, 0, 1, 1}; // -> LINKRESET
        vecs[5]  = '{4'h0, 1, 0, 1, 0, 4'h9, 0, 1, 1}; // hold
        vecs[6]  = '{4'hC, 1, 0, 1, 0, 4'hC, 0, 1, 1}; // LINKRESET -> DISABLED
        vecs[7]  = '{4'h9, 1, 0, 1, 0, 4'hC, 0, 1, 1}; // reverse refused
        vecs[8]  = '{4'h1, 1, 0, 1, 0, 4'h0, 0, 1, 1}; // -> RESET
        vecs[9]  = '{4'h1, 1, 0, 1, 0, 4'h0, 1, 1, 1}; // -> COUNT
        vecs[10] = '{4'h0, 1, 0, 1, 0, 4'h0, 0, 1, 1}; // abort on req NOP
        vecs[11] = '{4'h0, 1, 0, 1, 1, 4'h0, 0, 1, 1}; // stray done ignored
        vecs[12] = '{4'h1, 1, 0, 1, 0, 4'h0, 1, 1, 1}; // -> COUNT
        vecs[13] = '{4'h1, 0, 0, 1, 0, 4'h0, 0, 0, 1}; // abort on wake drop
        vecs[14] = '{4'h1, 1, 0, 1, 0, 4'h0, 0, 1, 1}; // ack not yet seen
        vecs[15] = '{4'h1, 1, 0, 1, 0, 4'h0, 1, 1, 1}; // -> COUNT
        vecs[16] = '{4'h1, 1, 0, 0, 0, 4'h0, 0, 1, 0}; // abort on linkup drop
        vecs[17] = '{4'h1, 1, 0, 1, 0, 4'h0, 0, 1, 1}; // pres not yet seen
        vecs[18] = '{4'h1, 1, 0, 1, 0, 4'h0, 1, 1, 1}; // -> COUNT
        vecs[19] = '{4'h1, 1, 0, 1, 1, 4'h1, 0, 1, 1}; // -> ACTIVE
        vecs[20] = '{4'h5, 1, 0, 1, 0, 4'h1, 0, 1, 1}; // unlisted req = NOP
        vecs[21] = '{4'hC, 1, 0, 1, 0, 4'hC, 0, 1, 1}; // -> DISABLED
        vecs[22] = '{4'h1, 1, 0, 1, 0, 4'h0, 0, 1, 1}; // -> RESET

        rst = 1'b1; req = 4'h0; wake = 1'b0; lerr = 1'b0; linkup = 1'b0; done = 1'b0;
        #12;
        chk_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table: inputs applied after an edge, outputs sampled after the next one.
        for (int i = 0; i < 23; i++) begin
            req = vecs[i].req; wake = vecs[i].wake; lerr = vecs[i].lerr;
            linkup = vecs[i].linkup; done = vecs[i].done;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_sts, vecs[i].e_cen,
                    vecs[i].e_ack, vecs[i].e_pres);
        end

        // LinkError from ACTIVE with 16-cycle residency after release.
        req = 4'h1; wake = 1'b1; linkup = 1'b1; done = 1'b0;
        tick();                        // COUNT
        done = 1'b1;
        tick();                        // ACTIVE
        done = 1'b0;
        chk("le_pre.sts", sts, 4'h1);
        lerr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("le_hold%0d.sts", i), sts, 4'hA);
            chk($sformatf("le_hold%0d.ack", i), {3'b0, ack}, 4'h0);
        end
        lerr = 1'b0;
        n = 0;
        tick();
        while (sts == 4'hA && n < 40) begin
            n++;
            tick();
        end
        chk("le_residency", 4'(n), 4'(16));
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL le_residency_full: got %0d cycles expected 16", n);
        end
        chk("le_exit.sts", sts, 4'h0);
        chk("le_exit.ack", {3'b0, ack}, 4'h1);

        // Simultaneous done and linkerror in COUNT: linkerror wins.
        n = 0;
        while (!cen && n < 5) begin
            tick();
            n++;
        end
        chk("sim_in_count.cen", {3'b0, cen}, 4'h1);
        done = 1'b1; lerr = 1'b1;
        tick();
        chk("sim.sts", sts, 4'hA);
        chk("sim.cen", {3'b0, cen}, 4'h0);
        done = 1'b0; lerr = 1'b0; req = 4'h0;
        seen_active = 1'b0;
        n = 0;
        while (sts != 4'h0 && n < 40) begin
            tick();
            if (sts == 4'h1) seen_active = 1'b1;
            n++;
        end
        chk("sim_never_active", {3'b0, seen_active}, 4'h0);
        chk("sim_exit.sts", sts, 4'h0);

        // Asynchronous reset in the middle of COUNT.
        req = 4'h1;
        n = 0;
        while (!cen && n < 5) begin
            tick();
            n++;
        end
        chk("rst_in_count.cen", {3'b0, cen}, 4'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_all("post_rst", 4'h0, 1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
